// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared ALU arbiter.
// The slave modport is taken by the arbiter. The master modport is taken by the
// requesters and the ALU, for example a testbench.
interface alu_arbiter_if #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned DataW  = 4
);
    logic [NumReq-1:0]       req_valid;
    logic [NumReq-1:0]       req_ready;
    logic [NumReq*DataW-1:0] req_a;
    logic [NumReq*DataW-1:0] req_b;
    logic [NumReq*2-1:0]     req_op;
    logic [NumReq-1:0]       resp_valid;
    logic [NumReq-1:0]       resp_ready;
    logic [DataW:0]          resp_data;
    logic [DataW-1:0]        alu_a;
    logic [DataW-1:0]        alu_b;
    logic [1:0]              alu_opcode;
    logic [DataW:0]          alu_c;

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready, alu_c,
        output req_ready, resp_valid, resp_data, alu_a, alu_b, alu_opcode
    );

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready, alu_c,
        input  req_ready, resp_valid, resp_data, alu_a, alu_b, alu_opcode
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered ALU among NumReq
// requesters. One operation is in flight at a time: accept, wait out the ALU
// latency, then hold the result until the granted requester takes it.
module alu_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned DataW  = 4,
    parameter int unsigned AluLat = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_arbiter_if.slave  bus,
    output logic          busy_o,
    output logic [15:0]   op_count_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(AluLat + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DataW-1:0]  alu_a_q, alu_a_d;
    logic [DataW-1:0]  alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [DataW:0]    resp_data_q, resp_data_d;
    logic [15:0]       op_count_q, op_count_d;

    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   win_idx;
    logic              win_found;
    logic [NumReq-1:0] req_ready;
    logic [NumReq-1:0] resp_valid;

    // Round-robin search: start one past the last grant, first valid requester wins
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % NumReq);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Sequencer next-state, handshakes and datapath loads
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        resp_data_d  = resp_data_q;
        op_count_d   = op_count_q;
        req_ready    = '0;
        resp_valid   = '0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    alu_a_d      = bus.req_a[32'(win_idx) * DataW +: DataW];
                    alu_b_d      = bus.req_b[32'(win_idx) * DataW +: DataW];
                    alu_op_d     = bus.req_op[32'(win_idx) * 2 +: 2];
                    gnt_idx_d    = win_idx;
                    last_grant_d = win_idx;
                    cnt_d        = CntW'(AluLat);
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    resp_data_d = bus.alu_c;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                resp_valid[gnt_idx_q] = 1'b1;
                // Only the granted requester's resp_ready matters here
                if (bus.resp_ready[gnt_idx_q]) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers. Reset discards any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(NumReq - 1);
            gnt_idx_q    <= '0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_data_q  <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            resp_data_q  <= resp_data_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign busy_o         = (state_q != StIdle);
    assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered one-cycle ALU model.
module tb_alu_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned DataW  = 4;
    localparam int unsigned AluLat = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned g;

    // Hand-computed results for each requester's fixed operands
    // req0: 2+1=3, req1: 15+10=25, req2: 9&6=0, req3: 4-3=1
    logic [4:0] exp_res [4] = '{5'd3, 5'd25, 5'd0, 5'd1};

    alu_arbiter_if #(.NumReq(NumReq), .DataW(DataW)) bus ();

    alu_arbiter #(
        .NumReq (NumReq),
        .DataW  (DataW),
        .AluLat (AluLat)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .busy_o     (busy),
        .op_count_o (op_count)
    );

    always #5 clk = ~clk;

    // Registered ALU model
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_c <= '0;
        end else begin
            case (bus.alu_opcode)
                2'b00:   bus.alu_c <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                2'b01:   bus.alu_c <= {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                2'b10:   bus.alu_c <= {1'b0, bus.alu_a & bus.alu_b};
                default: bus.alu_c <= {1'b0, bus.alu_a | bus.alu_b};
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation from requester idx with resp_ready held high
    task automatic do_op(input int unsigned idx, input logic [4:0] exp, input string tag);
        bus.req_valid  = 4'(1 << idx);
        bus.resp_ready = '1;
        #1 chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(1 << idx));
        cyc();
        bus.req_valid = '0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        cyc();
        chk({tag, " early resp_valid"}, 32'(bus.resp_valid), 32'd0);
        cyc();
        chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'(1 << idx));
        chk({tag, " resp_data"}, 32'(bus.resp_data), 32'(exp));
        cyc();
        chk({tag, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_a      = {4'd4, 4'd9, 4'd15, 4'd2};
        bus.req_b      = {4'd3, 4'd6, 4'd10, 4'd1};
        bus.req_op     = {2'b01, 2'b10, 2'b00, 2'b00};

        // Reset state
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst op_count", 32'(op_count), 32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst resp_data", 32'(bus.resp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from req 0, then overflow width from req 1
        do_op(0, 5'd3, "single");
        chk("single op_count", 32'(op_count), 32'd1);
        do_op(1, 5'd25, "overflow");
        chk("overflow op_count", 32'(op_count), 32'd2);

        // Round-robin: pointer sits at 1, so grants run 2,3,0,1,...
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            g = (2 + k) % 4;
            #1 chk("rr grant", 32'(bus.req_ready), 32'(1 << g));
            cyc();
            chk("rr no ready in wait", 32'(bus.req_ready), 32'd0);
            cyc();
            cyc();
            chk("rr resp_valid", 32'(bus.resp_valid), 32'(1 << g));
            chk("rr resp_data", 32'(bus.resp_data), 32'(exp_res[g]));
            cyc();
        end
        bus.req_valid = '0;
        chk("rr op_count", 32'(op_count), 32'd10);

        // Backpressure on req 0 while req 1 waits
        bus.req_valid  = 4'b0001;
        bus.resp_ready = 4'b0000;
        #1 chk("bp grant", 32'(bus.req_ready), 32'b0001);
        cyc();
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 4'b1110;
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp resp_valid", 32'(bus.resp_valid), 32'b0001);
            chk("bp resp_data", 32'(bus.resp_data), 32'd3);
            chk("bp busy", 32'(busy), 32'd1);
            chk("bp req_ready", 32'(bus.req_ready), 32'd0);
            cyc();
        end
        bus.resp_ready = 4'b0001;
        #1 chk("bp no bypass", 32'(bus.req_ready), 32'd0);
        cyc();
        chk("bp req1 ready", 32'(bus.req_ready), 32'b0010);
        chk("bp resp_valid drop", 32'(bus.resp_valid), 32'd0);
        chk("bp op_count", 32'(op_count), 32'd11);
        cyc();
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        cyc();
        cyc();
        chk("bp req1 resp_valid", 32'(bus.resp_valid), 32'b0010);
        chk("bp req1 resp_data", 32'(bus.resp_data), 32'd25);
        cyc();
        chk("bp op_count 2", 32'(op_count), 32'd12);

        // Reset in the middle of WAIT for req 2
        bus.req_valid = 4'b0100;
        #1 chk("mid grant", 32'(bus.req_ready), 32'b0100);
        cyc();
        bus.req_valid = '0;
        chk("mid busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid rst alu_a", 32'(bus.alu_a), 32'd0);
        chk("mid rst alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("mid rst resp_data", 32'(bus.resp_data), 32'd0);
        chk("mid rst op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'b0101;
        #1 chk("post rst grant", 32'(bus.req_ready), 32'b0001);
        cyc();
        bus.req_valid = '0;
        chk("post rst alu_a", 32'(bus.alu_a), 32'd2);
        cyc();
        cyc();
        chk("post rst resp_data", 32'(bus.resp_data), 32'd3);
        cyc();
        chk("post rst op_count", 32'(op_count), 32'd1);

        // Counter wrap: preload the count near the top instead of 65536 operations
        force dut.op_count_q = 16'hFFFE;
        #1 release dut.op_count_q;
        chk("wrap preload", 32'(op_count), 32'hFFFE);
        do_op(1, 5'd25, "wrap a");
        chk("wrap ffff", 32'(op_count), 32'hFFFF);
        do_op(2, 5'd0, "wrap b");
        chk("wrap zero", 32'(op_count), 32'd0);
        chk("wrap busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
